// File: rtl/sha256_pkg.sv
// sha256_pkg: shared state encoding and round constants for the SHA-256 controller.
package sha256_pkg;
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_ROUND, S_FINAL, S_DONE} state_t;
    localparam int SHA_ROUNDS = 64;
    localparam int SHA_SCHED_RAW = 16;
    localparam int SHA_RND_W = 6;
endpackage

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: round/pass sequencer for a multi-pass SHA-256 compression datapath.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int ROUNDS = SHA_ROUNDS,
    parameter int PASSES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 hold,
    output logic                 busy,
    output logic                 done,
    output logic                 init,
    output logic [SHA_RND_W-1:0] round,
    output logic [SHA_RND_W-1:0] k_addr,
    output logic                 w_sel,
    output logic                 upd_en,
    output logic                 h_upd,
    output logic [1:0]           pass,
    output logic                 pass_first
);
    localparam logic [SHA_RND_W-1:0] RND_LAST = SHA_RND_W'(ROUNDS - 1);
    localparam logic [1:0] PASS_LAST = 2'(PASSES - 1);

    state_t state, state_n;
    logic [SHA_RND_W-1:0] round_n;
    logic [1:0] pass_n;
    logic stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            round <= '0;
            pass  <= '0;
        end else begin
            state <= state_n;
            round <= round_n;
            pass  <= pass_n;
        end
    end

    assign stall = hold && (state == S_INIT || state == S_ROUND || state == S_FINAL);

    always_comb begin
        state_n = state;
        round_n = round;
        pass_n  = pass;
        if (!stall) begin
            case (state)
                S_IDLE:  state_n = start ? S_INIT : S_IDLE;
                S_INIT:  state_n = S_ROUND;
                S_ROUND: begin
                    // counter saturates at the last round so it never wraps
                    state_n = (round == RND_LAST) ? S_FINAL : S_ROUND;
                    round_n = (round == RND_LAST) ? round : round + 1'b1;
                end
                S_FINAL: begin
                    state_n = (pass == PASS_LAST) ? S_DONE : S_INIT;
                    pass_n  = (pass == PASS_LAST) ? pass : pass + 1'b1;
                    round_n = (pass == PASS_LAST) ? round : '0;
                end
                S_DONE: begin
                    state_n = S_IDLE;
                    round_n = '0;
                    pass_n  = '0;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign busy       = state != S_IDLE;
    assign done       = state == S_DONE;
    assign init       = state == S_INIT && !hold;
    assign upd_en     = (state == S_INIT || state == S_ROUND) && !hold;
    // suppressed during reset so an interrupted job never half-commits H
    assign h_upd      = state == S_FINAL && !hold && !rst;
    assign k_addr     = round;
    assign w_sel      = round >= SHA_RND_W'(SHA_SCHED_RAW);
    assign pass_first = pass == 2'd0;
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: step-list reference model, scenario table, random stress and an "abc" digest run.
module tb_sha256_round_ctrl;
    localparam int NR = 64;
    localparam int NP = 2;

    logic clk = 0, rst = 1, start = 0, hold = 0;
    logic busy, done, init, w_sel, upd_en, h_upd, pass_first;
    logic [5:0] rnd, k_addr;
    logic [1:0] pass;

    always #5 clk = ~clk;

    sha256_round_ctrl #(.ROUNDS(NR), .PASSES(NP)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done),
        .init(init), .round(rnd), .k_addr(k_addr), .w_sel(w_sel), .upd_en(upd_en),
        .h_upd(h_upd), .pass(pass), .pass_first(pass_first)
    );

    typedef enum {T_INIT, T_ROUND, T_FINAL, T_DONE} kind_t;
    typedef struct {kind_t kind; int rn; int ps;} stp_t;
    typedef struct {int hold_rnd; int hold_len; int start_rnd; int rst_rnd; int exp_done;} vec_t;

    stp_t q[$];
    int total = 0, bad = 0;
    logic chk_on = 0, dp_on = 0, obs_done;

    localparam logic [31:0] KR [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [31:0] IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] D_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_ABC2 = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

    logic [31:0] hs [8], wr [8], ws [64], msg [16];
    logic [255:0] dig1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic check_out();
        stp_t s;
        if (q.size() == 0) begin
            chk("busy", busy, 0); chk("done", done, 0); chk("init", init, 0);
            chk("round", rnd, 0); chk("k_addr", k_addr, 0); chk("w_sel", w_sel, 0);
            chk("upd_en", upd_en, 0); chk("h_upd", h_upd, 0); chk("pass", pass, 0);
            chk("pass_first", pass_first, 1);
        end else begin
            s = q[0];
            chk("busy", busy, 1);
            chk("done", done, s.kind == T_DONE);
            chk("init", init, s.kind == T_INIT && !hold);
            chk("round", rnd, s.rn);
            chk("k_addr", k_addr, s.rn);
            chk("w_sel", w_sel, s.rn >= 16);
            chk("upd_en", upd_en, (s.kind == T_INIT || s.kind == T_ROUND) && !hold);
            chk("h_upd", h_upd, s.kind == T_FINAL && !hold && !rst);
            chk("pass", pass, s.ps);
            chk("pass_first", pass_first, s.ps == 0);
        end
    endtask

    task automatic advance();
        if (rst) q.delete();
        else if (q.size() == 0) begin
            if (start) begin
                for (int p = 0; p < NP; p++) begin
                    q.push_back('{T_INIT, 0, p});
                    for (int r = 0; r < NR; r++) q.push_back('{T_ROUND, r, p});
                    q.push_back('{T_FINAL, NR - 1, p});
                end
                q.push_back('{T_DONE, NR - 1, NP - 1});
            end
        end else if (!(hold && q[0].kind != T_DONE)) void'(q.pop_front());
    endtask

    task automatic dp_tick();
        logic [31:0] t1, t2, s0, s1, w;
        int r;
        if (init) begin
            for (int i = 0; i < 16; i++) msg[i] = 32'h0;
            if (pass_first) begin
                msg[0] = 32'h61626380; msg[15] = 32'h18;
            end else begin
                for (int i = 0; i < 8; i++) msg[i] = dig1[255 - 32*i -: 32];
                msg[8] = 32'h80000000; msg[15] = 32'h100;
            end
            for (int i = 0; i < 8; i++) begin hs[i] = IV[i]; wr[i] = IV[i]; end
        end else if (upd_en) begin
            r = int'(rnd);
            if (w_sel && r >= 16) begin
                s0 = rotr(ws[r-15], 7) ^ rotr(ws[r-15], 18) ^ (ws[r-15] >> 3);
                s1 = rotr(ws[r-2], 17) ^ rotr(ws[r-2], 19) ^ (ws[r-2] >> 10);
                w = ws[r-16] + s0 + ws[r-7] + s1;
            end else w = (!w_sel && r < 16) ? msg[r] : 32'h0;
            ws[r] = w;
            t1 = wr[7] + (rotr(wr[4], 6) ^ rotr(wr[4], 11) ^ rotr(wr[4], 25))
               + ((wr[4] & wr[5]) ^ (~wr[4] & wr[6])) + KR[k_addr] + w;
            t2 = (rotr(wr[0], 2) ^ rotr(wr[0], 13) ^ rotr(wr[0], 22))
               + ((wr[0] & wr[1]) ^ (wr[0] & wr[2]) ^ (wr[1] & wr[2]));
            for (int i = 7; i > 0; i--) wr[i] = wr[i-1];
            wr[4] = wr[4] + t1;
            wr[0] = t1 + t2;
        end else if (h_upd) begin
            for (int i = 0; i < 8; i++) hs[i] = hs[i] + wr[i];
            if (pass_first) dig1 = {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]};
        end
    endtask

    task automatic step(input logic s, input logic h, input logic r);
        @(negedge clk);
        start = s; hold = h; rst = r;
        #1;
        obs_done = done;
        if (chk_on) check_out();
        if (dp_on) dp_tick();
        @(posedge clk);
        advance();
    endtask

    vec_t vecs [7];
    int ndone, dcyc, hl, c;
    logic h, s, r;
    logic [255:0] fin;

    initial begin
        // hold at round (pass 0), hold length, extra start at round, reset at round (pass 1), done cycle (0 = none)
        vecs[0] = '{-1, 0, -1, -1, 133};
        vecs[1] = '{20, 3, -1, -1, 136};
        vecs[2] = '{-1, 0, 30, -1, 133};
        vecs[3] = '{-1, 0, -1, 40, 0};
        vecs[4] = '{-1, 0, -1, -1, 133};
        vecs[5] = '{0, 5, -1, -1, 138};
        vecs[6] = '{63, 2, -1, -1, 135};

        step(0, 0, 1);
        step(0, 0, 1);
        chk_on = 1;
        step(0, 0, 1);
        step(0, 1, 0);

        foreach (vecs[v]) begin
            step(1, 0, 0);
            ndone = 0; dcyc = 0; hl = 0; c = 1;
            while (q.size() != 0 && c < 400) begin
                h = vecs[v].hold_rnd >= 0 && q[0].kind == T_ROUND && q[0].ps == 0
                    && q[0].rn == vecs[v].hold_rnd && hl < vecs[v].hold_len;
                if (h) hl++;
                s = q[0].kind == T_ROUND && q[0].rn == vecs[v].start_rnd;
                r = vecs[v].rst_rnd >= 0 && q[0].kind == T_ROUND && q[0].ps == 1 && q[0].rn == vecs[v].rst_rnd;
                step(s, h, r);
                if (obs_done) begin ndone++; if (dcyc == 0) dcyc = c; end
                c++;
            end
            step(0, 0, 0);
            chk($sformatf("done_cycle[%0d]", v), dcyc, vecs[v].exp_done);
            chk($sformatf("done_count[%0d]", v), ndone, vecs[v].exp_done != 0);
        end

        dp_on = 1;
        step(1, 0, 0);
        c = 0;
        while (q.size() != 0 && c < 400) begin step(0, 0, 0); c++; end
        dp_on = 0;
        fin = {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]};
        total++;
        if (dig1 !== D_ABC) begin bad++; $display("FAIL digest_abc: got %h want %h", dig1, D_ABC); end
        total++;
        if (fin !== D_ABC2) begin bad++; $display("FAIL digest_abc2: got %h want %h", fin, D_ABC2); end

        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Round sequencer for the SHA-256 compression datapath. It drives the select line that makes each working register (a..h) load either the intermediate hash value or the round result t. It also steps the 64-round counter, addresses the K constant ROM and message-schedule mux, and commits the final H update. For double-SHA (mining) it repeats the compression for a configurable number of passes, then reports completion with a start/done handshake.

## Interface
- ROUNDS, 64, rounds per compression; counter width is clog2(ROUNDS)
- PASSES, 2, compressions per job (2 = SHA-256d); legal range 1..4
- clk  input  1  system clock; the controller updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  job request; sampled only in IDLE
- hold  input  1  stall; freezes the counter and the state while high (for example, while message words are not ready)
- busy  output  1  high from the accept edge until done falls
- done  output  1  one-cycle pulse when the last pass has committed
- init  output  1  control to the working registers; 1 = load H, 0 = load t
- round  output  6  current round index, 0..ROUNDS-1
- k_addr  output  6  K ROM address; equals round
- w_sel  output  1  0 = raw message word (round < 16), 1 = expanded schedule word
- upd_en  output  1  working registers and schedule advance this cycle
- h_upd  output  1  add a..h into H this cycle
- pass  output  2  current pass index, 0..PASSES-1
- pass_first  output  1  pass == 0: the datapath selects the IV/midstate as H source, otherwise the digest of the previous pass

## Operation
- States: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE:
  - Outputs: busy=0, init=0, upd_en=0, round=0, pass=0.
  - start=1 → INIT.
- INIT:
  - init=1, upd_en=1; the working registers load H.
  - Next state: ROUND, with round=0.
- ROUND:
  - init=0, upd_en=1, w_sel=(round>=16).
  - round increments each non-held cycle.
  - At round==ROUNDS-1 the next state is FINAL; round stays at ROUNDS-1.
- FINAL:
  - h_upd=1, upd_en=0.
  - If pass<PASSES-1: pass++, next state INIT.
  - Otherwise: next state DONE.
- DONE:
  - done=1, busy=1 for this cycle only.
  - Next state: IDLE; pass and round clear to 0.
- hold=1 (any state except IDLE and DONE):
  - State, round and pass are frozen.
  - upd_en=0, h_upd=0, init=0 for that cycle.
  - Once hold drops, the frozen step executes.
- hold in IDLE and DONE: ignored.
- start while busy: ignored, with no queuing.
- start held high through DONE: a new job is accepted on the first IDLE cycle.
- rst=1 at any cycle, including mid-round:
  - Next state IDLE; all outputs take their IDLE values.
  - h_upd is never asserted in the reset cycle, so no partial H commit occurs.
- Reset values: busy=0, done=0, init=0, round=0, k_addr=0, w_sel=0, upd_en=0, h_upd=0, pass=0, pass_first=1.
- All outputs are registered or decoded from registered state only. There is no combinational path from start or hold to any output except the upd_en/h_upd/init gating by hold.

## Timing
- Rising edge N samples start=1 in IDLE. In cycle N+1 the state is INIT and busy=1.
- The working registers sample init on the falling edge. Controller outputs therefore have a half cycle of setup before the datapath captures them.
- Per pass with no hold: 1 INIT + ROUNDS ROUND + 1 FINAL = 66 cycles.
- done is high in cycle N+1+66×PASSES: cycle 133 for PASSES=2, cycle 67 for PASSES=1.
- Each cycle of hold adds exactly one cycle of latency.
- round wrap-around never occurs, because the counter saturates at ROUNDS-1 and is cleared on INIT.

## Structure
- Shared sha256_pkg holds:
  - the state enum
  - SHA_ROUNDS=64
  - SHA_SCHED_RAW=16
  - SHA_RND_W=6
- No sub-module: a single FSM plus a round counter and a pass counter. The K ROM stays in the datapath and is addressed by k_addr.

## Test plan
- Reset, then start pulse with PASSES=2 → init=1 at cycle 1; round runs 0..63 over cycles 2..65; h_upd at cycle 66 and cycle 132; done at cycle 133; busy falls at cycle 134.
- w_sel check → w_sel=0 for rounds 0..15 and 1 for rounds 16..63; k_addr==round every cycle.
- hold high for 3 cycles at round 20 → round holds at 20 and upd_en=0 for those 3 cycles; done arrives 3 cycles later (cycle 136).
- start pulsed at round 30 → ignored; at most one done; round sequence unaffected.
- rst asserted at round 40 of pass 1 → next cycle shows all IDLE values; no done; a following start yields a full, normal job.
- Directed job against the datapath with the "abc" block → digest matches the published SHA-256 value; with PASSES=2 the result matches SHA-256d("abc").
